// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/writeback and drives datapath controls.
// Optional jal support is enabled by defining MC_CONTROLLER_JAL_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FETCH     | PC+4, load IR and PC on the last wait cycle
// DECODE    | read registers, precompute branch target, dispatch on op
// MEMADR    | effective address = A + SignImm
// MEMRD     | data memory read at ALUOut (waits MEM_WAIT cycles)
// MEMWB     | write loaded data to rt
// MEMWR     | data memory write at ALUOut (strobe on last wait cycle)
// RTYPEEX   | ALU operation selected by funct
// RTYPEWB   | write ALUOut to rd
// BEQEX     | compare A-B, PC <= branch target when zero
// ADDIEX    | A + SignImm
// ADDIWB    | write ALUOut to rt
// JEX       | PC <= jump target
// JALEX     | PC <= jump target, r31 <= PC+4 (MC_CONTROLLER_JAL_EN only)
module mc_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       memwrite,
  output logic       lord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       branch,
  output logic       pcwrite,
  output logic       link,
  output logic       illegal
);

  localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROLLER_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX,
    S_JALEX
  } state_t;

  typedef struct packed {
    logic       memwrite;
    logic       lord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       branch;
    logic       pcwrite;
    logic       link;
  } ctrl_t;

  // Moore output table; 'last' marks the final cycle of a wait-extended state.
  function automatic ctrl_t ctrl_of(input state_t s, input logic last);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = last;
        c.pcwrite = last;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.lord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.lord     = 1'b1;
        c.memwrite = last;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
`ifdef MC_CONTROLLER_JAL_EN
      S_JALEX: begin
        c.pcsrc    = 2'b10;
        c.pcwrite  = 1'b1;
        c.regwrite = 1'b1;
        c.link     = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  state_t     r_state;
  logic [3:0] r_cnt;
  ctrl_t      r_ctrl;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_last;
  logic       w_last_nxt;
  logic       w_illegal;

  assign w_last     = (r_cnt == LP_WAIT);
  assign w_last_nxt = (w_cnt_nxt == LP_WAIT);

  // Counter clears on every state change, so entering a wait state always starts at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_last) w_state_nxt = S_DECODE;
        else        w_cnt_nxt   = r_cnt + 4'd1;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_RTYPE:     w_state_nxt = S_RTYPEEX;
          OP_BEQ:       w_state_nxt = S_BEQEX;
          OP_ADDI:      w_state_nxt = S_ADDIEX;
          OP_J:         w_state_nxt = S_JEX;
`ifdef MC_CONTROLLER_JAL_EN
          OP_JAL:       w_state_nxt = S_JALEX;
`endif
          default: begin
            w_illegal   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  w_state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (w_last) w_state_nxt = S_MEMWB;
        else        w_cnt_nxt   = r_cnt + 4'd1;
      end
      S_MEMWR: begin
        if (w_last) w_state_nxt = S_FETCH;
        else        w_cnt_nxt   = r_cnt + 4'd1;
      end
      S_RTYPEEX: w_state_nxt = S_RTYPEWB;
      S_ADDIEX:  w_state_nxt = S_ADDIWB;
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_ctrl  <= ctrl_of(S_FETCH, LP_WAIT == 4'd0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= ctrl_of(w_state_nxt, w_last_nxt);
    end
  end

  // Strobes are masked while reset is held so the IR/PC are never loaded during reset.
  assign memwrite = r_ctrl.memwrite & ~reset;
  assign irwrite  = r_ctrl.irwrite  & ~reset;
  assign regwrite = r_ctrl.regwrite & ~reset;
  assign pcwrite  = r_ctrl.pcwrite  & ~reset;
  assign lord     = r_ctrl.lord;
  assign regdst   = r_ctrl.regdst;
  assign memtoreg = r_ctrl.memtoreg;
  assign alusrca  = r_ctrl.alusrca;
  assign alusrcb  = r_ctrl.alusrcb;
  assign aluop    = r_ctrl.aluop;
  assign pcsrc    = r_ctrl.pcsrc;
  assign branch   = r_ctrl.branch;
  assign link     = r_ctrl.link;
  assign illegal  = (r_state == S_DECODE) && w_illegal;

endmodule
